// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, header length field and egress framing states.
package router_pkg;

  localparam int FLIT_W  = 64;
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 8;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } egress_state_t;

  // A zero length field still describes a one-flit (header only) packet.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/egress_buf.sv
// Two-entry in-order flit buffer; push and pop may both happen in one cycle.
module egress_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Entries reset to zero so the head reads 0 until the first capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/router_egress.sv
// Egress stage: credit-limited FIFO reads into a 2-flit buffer plus HEAD/BODY framing.
// Optional macro ROUTER_EGRESS_STATS_EN adds a 32-bit completed-packet counter (pkt_count).
//
// Handshake: a flit moves downstream on a rising edge where out_valid and out_ready are
// both high; while out_valid is high and out_ready low, out_data/out_sop/out_eop hold.
module router_egress
  import router_pkg::*;
#(
  parameter int WIDTH = FLIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  output logic             pop,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output egress_state_t    state
`ifdef ROUTER_EGRESS_STATS_EN
  ,
  output logic [31:0]      pkt_count
`endif
);

  logic [1:0]       buf_count;
  logic [1:0]       inflight;
  logic             capture;
  logic             xfer;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] remaining;

  assign out_valid = (buf_count != 2'd0);
  assign xfer      = out_valid & out_ready;
  // Read data returns one cycle after its pop, so at most one read is ever in flight.
  assign capture   = (inflight != 2'd0);
  assign pop       = !empty &&
                     (({1'b0, buf_count} + {1'b0, inflight} - {2'b00, xfer}) < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 2'd0;
    end else begin
      inflight <= inflight + {1'b0, pop} - {1'b0, capture};
    end
  end

  egress_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (capture),
    .push_data(mem_rd_data),
    .pop      (xfer),
    .head     (out_data),
    .count    (buf_count)
  );

  assign len_eff = eff_len(out_data[LEN_LSB +: LEN_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HEAD;
      remaining <= '0;
    end else if (xfer) begin
      case (state)
        HEAD: begin
          remaining <= len_eff - LEN_W'(1);
          if (len_eff > LEN_W'(1)) begin
            state <= BODY;
          end
        end
        BODY: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= HEAD;
          end
        end
        default: state <= HEAD;
      endcase
    end
  end

  assign out_sop = out_valid && (state == HEAD);
  assign out_eop = out_valid &&
                   (((state == HEAD) && (len_eff == LEN_W'(1))) ||
                    ((state == BODY) && (remaining == LEN_W'(1))));

`ifdef ROUTER_EGRESS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= 32'd0;
    end else if (xfer && out_eop) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/router_egress.md
ROUTER_EGRESS -- requirements
Module: router_egress

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning flit width in bits (minimum 16).
REQ-002 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port empty  input  1  upstream FIFO holds no flits.
REQ-005 SHALL have port pop  output  1  requests one flit from the upstream FIFO this cycle.
REQ-006 SHALL have port mem_rd_data  input  WIDTH  popped flit, valid exactly one cycle after pop.
REQ-007 SHALL have port out_valid  output  1  out_data holds a flit.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the flit this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  flit presented downstream.
REQ-010 SHALL have ports out_sop and out_eop  output  1 each  first and last flit of a packet.

Function
REQ-011 SHALL treat a transfer as occurring when out_valid and out_ready are both high at a rising edge.
REQ-012 SHALL hold a 2-entry in-order flit buffer plus an in-flight counter of pops whose data has not yet returned.
REQ-013 SHALL assert pop only when empty is low and (buffered + in-flight − transfers this cycle) < 2.
REQ-014 SHALL capture mem_rd_data into the buffer on the edge ending the cycle after each pop.
REQ-015 SHALL give 2-cycle latency: a pop in cycle t yields out_valid in cycle t+2 if the buffer was empty.
REQ-016 SHALL sustain one transfer per cycle when empty stays low and out_ready stays high.
REQ-017 SHALL keep out_data, out_sop and out_eop stable while out_valid is high and out_ready is low.
REQ-018 SHALL never drop, duplicate or reorder flits; simultaneous capture and transfer in one cycle is legal.
REQ-019 SHALL run a framing FSM with states HEAD and BODY, starting in HEAD.
REQ-020 SHALL, in HEAD, read flit length L from header bits [7:0], count header included, with L=0 treated as 1.
REQ-021 SHALL set remaining = L−1 on a HEAD transfer, stay in HEAD if L≤1, else go to BODY.
REQ-022 SHALL decrement remaining on each BODY transfer and return to HEAD when it reaches 0.
REQ-023 SHALL drive out_sop = out_valid in HEAD, and out_eop = out_valid when (HEAD and L≤1) or (BODY and remaining=1).
REQ-024 SHALL wrap remaining counting correctly for L=255 (8-bit counter).

Reset
REQ-025 SHALL, on reset, clear the buffer and in-flight counter, enter HEAD, and drive pop=0 and out_valid/out_sop/out_eop=0.
REQ-026 SHALL, on reset mid-packet or mid-read, discard any returning read data; the upstream FIFO is reset by the same signal.
REQ-027 SHALL hold out_data at 0 after reset until the first capture.

Configuration
REQ-028 SHALL, with ROUTER_EGRESS_STATS_EN defined, add output pkt_count (32 bits), reset to 0, incremented on each transfer with out_eop high, wrapping at 2^32.
REQ-029 SHALL, without ROUTER_EGRESS_STATS_EN, have no pkt_count port and no counter logic.

Structure
REQ-030 SHALL take from shared package router_pkg: FLIT_W=64, LEN_LSB=0, LEN_W=8, and the egress_state_t enum {HEAD, BODY}.
REQ-031 SHALL place the 2-entry buffer in sub-module egress_buf (push/pop/count, WIDTH parameter); the FSM and pop/credit logic stay in router_egress.

Verification
REQ-032 SHALL cover single flit: FIFO holds header L=1, out_ready=1 -> pop at t, out_valid with sop=eop=1 at t+2, then idle.
REQ-033 SHALL cover streaming: 3 packets of L=4 back-to-back, out_ready=1 -> 12 consecutive transfers, sop on flits 1/5/9, eop on 4/8/12, pop never gapped.
REQ-034 SHALL cover backpressure: out_ready=0 for 10 cycles mid-packet -> at most 2 pops outstanding, out_data stable, no loss after out_ready=1.
REQ-035 SHALL cover L=0 header -> treated as single flit, sop=eop=1.
REQ-036 SHALL cover reset asserted in the cycle after a pop in BODY -> outputs 0 next cycle, FSM HEAD, returned data not presented.
REQ-037 SHALL cover, with ROUTER_EGRESS_STATS_EN, 5 packets of random L (1..8) -> pkt_count=5; bench also runs with the macro undefined.
